// File: rtl/trace_capture_buf.sv
// trace_capture_buf: arm/trigger controlled capture of the power-sensor sample
// stream into an on-chip trace buffer, with a synchronous read port exposing
// the buffer, capture state and stored-word count.
// Optional build macro TRACE_CAPTURE_ACCUM_EN: each stored word is the sum of
// 2^ACC_LOG2 consecutive valid samples instead of a single raw sample.
module trace_capture_buf #(
    parameter int SAMPLE_W   = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int WORD_W     = 32,
    parameter int ACC_LOG2   = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [SAMPLE_W-1:0]   sample_data,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WORD_W-1:0]     rd_data,
    output logic [1:0]            state_o,
    output logic [DEPTH_LOG2:0]   wr_count,
    output logic                  done,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // A stored word must hold a full accumulated group without overflow.
    if (WORD_W < SAMPLE_W + ACC_LOG2) begin : g_bad_word_w
        $error("trace_capture_buf: WORD_W must be >= SAMPLE_W + ACC_LOG2");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  trig_q;
    logic [DEPTH_LOG2:0]   wr_count_q, wr_count_d;
    logic                  overrun_q, overrun_d;
    logic [WORD_W-1:0]     rd_data_q;
    logic [WORD_W-1:0]     buf_mem [DEPTH];

    logic                  trig_rise;
    logic [WORD_W-1:0]     sample_ext;
    logic                  wr_en;
    logic [WORD_W-1:0]     wr_word;

`ifdef TRACE_CAPTURE_ACCUM_EN
    // A group counter of zero width is meaningless; accumulation needs ACC_LOG2 >= 1.
    if (ACC_LOG2 < 1) begin : g_bad_acc_log2
        $error("trace_capture_buf: ACC_LOG2 must be >= 1 with accumulation enabled");
    end

    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [ACC_LOG2-1:0]   grp_q, grp_d;
`endif

    // trigger_q holds last cycle's level, so a trigger already high at arm time
    // cannot fire until it has dropped and risen again.
    assign trig_rise  = trigger & ~trig_q;
    assign sample_ext = WORD_W'(sample_data);

    // Next-state, counter, sticky-flag and write-port decode; abort beats arm beats trigger.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        overrun_d  = overrun_q;
        wr_en      = 1'b0;
        wr_word    = sample_ext;
`ifdef TRACE_CAPTURE_ACCUM_EN
        acc_d      = acc_q;
        grp_d      = grp_q;
`endif

        // An accepted arm clears the sticky flag even if a late edge coincides.
        if (arm && !abort) begin
            overrun_d = 1'b0;
        end else if (trig_rise && (state_q == S_CAPTURE || state_q == S_DONE)) begin
            overrun_d = 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
`ifdef TRACE_CAPTURE_ACCUM_EN
            acc_d   = '0;
            grp_d   = '0;
`endif
        end else if (arm) begin
            state_d    = S_ARMED;
            wr_count_d = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig_rise) begin
                        state_d = S_CAPTURE;
`ifdef TRACE_CAPTURE_ACCUM_EN
                        acc_d   = '0;
                        grp_d   = '0;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
`ifdef TRACE_CAPTURE_ACCUM_EN
                        if (&grp_q) begin
                            wr_en   = 1'b1;
                            wr_word = acc_q + sample_ext;
                            acc_d   = '0;
                            grp_d   = '0;
                        end else begin
                            acc_d   = acc_q + sample_ext;
                            grp_d   = grp_q + 1'b1;
                        end
`else
                        wr_en = 1'b1;
`endif
                        if (wr_en) begin
                            wr_count_d = wr_count_q + 1'b1;
                            // Full buffer ends the capture; addresses never wrap.
                            if (wr_count_d[DEPTH_LOG2]) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            wr_count_q <= '0;
            overrun_q  <= 1'b0;
`ifdef TRACE_CAPTURE_ACCUM_EN
            acc_q      <= '0;
            grp_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            wr_count_q <= wr_count_d;
            overrun_q  <= overrun_d;
`ifdef TRACE_CAPTURE_ACCUM_EN
            acc_q      <= acc_d;
            grp_q      <= grp_d;
`endif
        end
    end

    // Trace buffer write port; contents are not reset.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            buf_mem[wr_count_q[DEPTH_LOG2-1:0]] <= wr_word;
        end
    end

    // Registered read port; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= buf_mem[rd_addr];
        end
    end

    assign rd_data  = rd_data_q;
    assign state_o  = state_q;
    assign wr_count = wr_count_q;
    assign done     = (state_q == S_DONE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Self-checking bench for trace_capture_buf: directed scenarios plus a
// randomized phase, all checked every cycle against a reference model.
module tb_trace_capture_buf;

    localparam int SAMPLE_W   = 8;
    localparam int DEPTH_LOG2 = 10;
    localparam int WORD_W     = 32;
    localparam int ACC_LOG2   = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef TRACE_CAPTURE_ACCUM_EN
    localparam int GRP = 1 << ACC_LOG2;
`else
    localparam int GRP = 1;
`endif

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic [SAMPLE_W-1:0]   sample_data;
    logic                  sample_valid;
    logic                  arm;
    logic                  trigger;
    logic                  abort;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [WORD_W-1:0]     rd_data;
    logic [1:0]            state_o;
    logic [DEPTH_LOG2:0]   wr_count;
    logic                  done;
    logic                  overrun;

    trace_capture_buf #(
        .SAMPLE_W  (SAMPLE_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .WORD_W    (WORD_W),
        .ACC_LOG2  (ACC_LOG2)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .arm         (arm),
        .trigger     (trigger),
        .abort       (abort),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .state_o     (state_o),
        .wr_count    (wr_count),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: modes 0 idle, 1 armed, 2 capturing, 3 full.
    int          m_mode;
    int          m_count;
    bit          m_over;
    bit          m_trig_prev;
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int unsigned m_acc;
    int          m_grp;
    logic [31:0] exp_rd;
    bit          exp_rd_known;
    bit          rd_rand;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_count     = 0;
        m_over      = 1'b0;
        m_trig_prev = 1'b0;
        m_acc       = 0;
        m_grp       = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        exp_rd       = 32'h0;
        exp_rd_known = 1'b1;
    endtask

    task automatic store_word(input logic [31:0] w);
        m_mem[m_count]   = w;
        m_known[m_count] = 1'b1;
        m_count++;
        if (m_count == DEPTH) m_mode = 3;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit rise;
        if (ARESET) begin
            model_reset();
            return;
        end
        rise         = trigger && !m_trig_prev;
        exp_rd       = m_mem[rd_addr];
        exp_rd_known = m_known[rd_addr];
        if (arm && !abort)                   m_over = 1'b0;
        else if (rise && m_mode >= 2)        m_over = 1'b1;
        if (abort) begin
            m_mode = 0;
            m_acc  = 0;
            m_grp  = 0;
        end else if (arm) begin
            m_mode  = 1;
            m_count = 0;
        end else if (m_mode == 1 && rise) begin
            m_mode = 2;
            m_acc  = 0;
            m_grp  = 0;
        end else if (m_mode == 2 && sample_valid) begin
            m_acc += 32'(sample_data);
            m_grp++;
            if (m_grp == GRP) begin
                store_word(m_acc);
                m_acc = 0;
                m_grp = 0;
            end
        end
        m_trig_prev = trigger;
    endtask

    // One clock: model update, edge, then compare every output.
    task automatic tick();
        if (rd_rand) rd_addr = DEPTH_LOG2'($urandom);
        model_step();
        @(posedge ACLK);
        #1;
        chk("state", state_o, m_mode);
        chk("wr_count", wr_count, m_count);
        chk("done", done, (m_mode == 3));
        chk("overrun", overrun, m_over);
        if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        ARESET       = 1'b1;
        sample_data  = '0;
        sample_valid = 1'b0;
        arm          = 1'b0;
        trigger      = 1'b0;
        abort        = 1'b0;
        rd_addr      = '0;
        rd_rand      = 1'b1;
        model_reset();

        // Reset values
        tick();
        tick();
        chk("rst_rd_data", rd_data, 32'h0);
        ARESET = 1'b0;
        tick();

        // Full capture of a ramp
        pulse_arm();
        trigger = 1'b1;
        tick();
        chk("t1_capture", state_o, 2'd2);
        for (int i = 0; i < DEPTH * GRP; i++) begin
            sample_data  = i[7:0];
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        chk("t1_done", done, 1'b1);
        chk("t1_count", wr_count, 11'd1024);
        rd_rand = 1'b0;
        rd_addr = 10'd5;
        tick();
`ifndef TRACE_CAPTURE_ACCUM_EN
        chk("t1_rd5", rd_data, 32'h5);
`endif
        rd_rand = 1'b1;

        // Trigger high across arm must not fire
        tick();
        pulse_arm();
        for (int i = 0; i < 100; i++) begin
            sample_data  = SAMPLE_W'($urandom);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        chk("t2_still_armed", state_o, 2'd1);
        chk("t2_count0", wr_count, 11'd0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        chk("t2_capture", state_o, 2'd2);

        // 300 samples then abort together with arm
        for (int i = 0; i < 300 * GRP; i++) begin
            sample_data  = SAMPLE_W'($urandom);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        chk("t3_idle", state_o, 2'd0);
        chk("t3_count", wr_count, 11'd300);
        chk("t3_done", done, 1'b0);
        rd_rand = 1'b0;
        for (int a = 0; a < 300; a++) begin
            rd_addr = DEPTH_LOG2'(a);
            tick();
        end
        rd_rand = 1'b1;

        // Capture with a toggling valid, then overrun in DONE
        trigger = 1'b0;
        pulse_arm();
        trigger = 1'b1;
        tick();
        for (int n = 0; n < 6 * DEPTH * GRP && m_mode != 3; n++) begin
            sample_data  = SAMPLE_W'($urandom);
            sample_valid = n[0];
            tick();
        end
        sample_valid = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_count", wr_count, 11'd1024);
        rd_rand = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = DEPTH_LOG2'(a);
            tick();
        end
        rd_rand = 1'b1;
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        chk("t4_overrun", overrun, 1'b1);
        repeat (5) tick();
        chk("t4_overrun_sticky", overrun, 1'b1);
        pulse_arm();
        chk("t4_arm_over", overrun, 1'b0);
        chk("t4_arm_done", done, 1'b0);
        chk("t4_arm_count", wr_count, 11'd0);

        // Asynchronous reset mid-capture at 512 words
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        for (int n = 0; n < 4 * DEPTH * GRP && m_count < 512; n++) begin
            sample_data  = SAMPLE_W'($urandom);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        chk("t5_at512", wr_count, 11'd512);
        #3;
        ARESET = 1'b1;
        #1;
        chk("t5_async_state", state_o, 2'd0);
        chk("t5_async_count", wr_count, 11'd0);
        chk("t5_async_done", done, 1'b0);
        tick();
        ARESET  = 1'b0;
        trigger = 1'b0;
        tick();

        // Randomized control and data
        for (int n = 0; n < 4000; n++) begin
            arm          = ($urandom_range(0, 199) == 0);
            abort        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) trigger = ~trigger;
            sample_valid = $urandom_range(0, 1) == 1;
            sample_data  = SAMPLE_W'($urandom);
            tick();
        end
        arm          = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;

`ifdef TRACE_CAPTURE_ACCUM_EN
        // Accumulation of samples 1..8 into two words
        trigger = 1'b0;
        pulse_arm();
        trigger = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            sample_data  = SAMPLE_W'(i);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        chk("acc_count", wr_count, 11'd2);
        rd_rand = 1'b0;
        rd_addr = 10'd0;
        tick();
        chk("acc_w0", rd_data, 32'h0A);
        rd_addr = 10'd1;
        tick();
        chk("acc_w1", rd_data, 32'h1A);
        rd_rand = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_capture_buf.md
Name: trace_capture_buf

Overview:
- Upstream feeder for the read-only AXI4-Lite register peripheral in the power side-channel design.
- Samples the delay-line power-sensor word stream into an on-chip trace buffer after an arm + trigger sequence.
- Exposes the buffer, capture status and sample count through a synchronous read port. The AXI read-only slave maps that read port into its register space.

Parameters:
- SAMPLE_W, 8, width of one sensor sample (popcount/thermometer-decoded sensor output).
- DEPTH_LOG2, 10, log2 of trace buffer depth in words (1024 words at default).
- WORD_W, 32, stored word width; must be >= SAMPLE_W + ACC_LOG2.
- ACC_LOG2, 2, log2 of samples summed per stored word (used only with accumulation enabled).

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- sample_data  in  SAMPLE_W  sensor sample.
- sample_valid  in  1  sample_data qualifier; one sample per asserted cycle.
- arm  in  1  single-cycle pulse; starts a capture.
- trigger  in  1  level from the victim circuit; rising edge starts recording.
- abort  in  1  single-cycle pulse; returns to IDLE and keeps data already written.
- rd_addr  in  DEPTH_LOG2  buffer read address.
- rd_data  out  WORD_W  buffer word at rd_addr, 1-cycle latency.
- state_o  out  2  current FSM state encoding.
- wr_count  out  DEPTH_LOG2+1  words stored in current/last capture.
- done  out  1  high in DONE state.
- overrun  out  1  sticky; trigger edge seen while CAPTURE or DONE.

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE.
  - wr_count=0, done=0, overrun=0, rd_data=0.
  - Trigger edge register=0, accumulator=0.
  - Buffer contents undefined.
- FSM encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE:
  - arm -> ARMED.
  - wr_count cleared to 0 on the same edge as the arm transition.
  - overrun cleared on arm.
- ARMED:
  - Trigger rising edge (trigger=1, registered trigger_q=0) -> CAPTURE.
  - A trigger already high at arm time does not fire; it must go low, then high.
- CAPTURE:
  - Each sample_valid cycle produces one stored word at address wr_count[DEPTH_LOG2-1:0]; wr_count then increments.
  - When wr_count reaches 2^DEPTH_LOG2 -> DONE. No wrap-around: the buffer is never overwritten within a capture.
  - A sample_valid gap stalls the capture with no penalty.
- DONE:
  - done=1; holds until the next arm.
  - arm -> ARMED, clears done, wr_count and overrun.
- abort:
  - In any state -> IDLE.
  - wr_count holds its value; done=0.
  - abort has priority over arm and trigger when asserted in the same cycle.
- overrun: set on a trigger rising edge while in CAPTURE or DONE; cleared only by arm or reset.
- arm while in ARMED or CAPTURE restarts capture: -> ARMED, wr_count=0.
- Same-cycle sample write and rd_addr read of the same address: rd_data returns the old word (read-first).
- Read port:
  - rd_data registered, valid the cycle after rd_addr.
  - Reads permitted in any state.
- Stored word: raw sample zero-extended to WORD_W.
- Reset mid-capture: immediate return to IDLE; outputs at reset values.

Optional Feature:
- Macro: TRACE_CAPTURE_ACCUM_EN.
- Defined:
  - CAPTURE sums 2^ACC_LOG2 consecutive valid samples into a WORD_W accumulator.
  - On the last sample of a group, the word written is (accumulator + current sample). The accumulator then reloads 0.
  - The sample counter resets on entry to CAPTURE.
  - A partial group at abort is discarded.
  - wr_count counts stored words, not samples.
- Undefined: every valid sample is stored raw; ACC_LOG2 is ignored; accumulator logic is absent.

Test Plan:
- Reset, arm pulse, trigger 0->1, drive sample_data=i[7:0] for 1024 valid cycles -> DONE, done=1, wr_count=1024, rd_addr=5 gives rd_data=0x00000005 one cycle later.
- Trigger held high across arm, then never toggled with 100 samples -> remains ARMED, wr_count=0. Drop then raise trigger -> CAPTURE starts on that edge.
- Capture 300 samples, pulse abort together with arm -> IDLE, wr_count=300, done=0; words 0..299 readable unchanged.
- In DONE, pulse trigger 0->1 -> overrun=1 and stays set. Next arm -> overrun=0, done=0, wr_count=0.
- Toggle sample_valid every other cycle during capture -> exactly 1024 writes, no skipped/duplicate addresses. Assert ARESET mid-capture at wr_count=512 -> state_o=0, wr_count=0 asynchronously.
- With TRACE_CAPTURE_ACCUM_EN, ACC_LOG2=2, samples 1,2,3,4,5,6,7,8 -> words 0x0A, 0x1A; wr_count=2.
